tlb_assoc_plru: RTL
===================

// Module: tlb_assoc_plru
// PURPOSE
// - Parametrised set-associative TLB array with tree-PLRU replacement, PCID-tagged entries and stored PPN translation.
// - Generalises the fixed 8-set/8-way presence-only set to any power-of-two SETS/WAYS.
// - Adds explicit fill, per-PCID/global flush and valid/ready lookup with 1-cycle response.
// - Sits between the address-generation stage (lookup) and the page walker (fill/flush).
// PARAMETERS
// - VA_W    64  virtual address width
// - PA_W    52  physical address width
// - PAGE_W  12  page offset width
// - PCID_W  12  process-context ID width
// - SETS     8  number of sets, power of 2, >=2
// - WAYS     8  ways per set, power of 2, >=2
// PORTS
// - clk          in   1                   clock, all state on posedge
// - rst_n        in   1                   reset, asynchronous, active-low
// - req_valid    in   1                   lookup request
// - req_ready    out  1                   lookup accepted when valid&ready
// - req_vaddr    in   VA_W                lookup virtual address
// - req_pcid     in   PCID_W              lookup PCID
// - rsp_valid    out  1                   response strobe, 1 cycle after accept
// - rsp_hit      out  1                   1=translation found
// - rsp_paddr    out  PA_W                {ppn, vaddr offset}; 0 on miss
// - rsp_way      out  $clog2(WAYS)        hitting way; 0 on miss
// - fill_valid   in   1                   install translation
// - fill_ready   out  1                   high in IDLE only
// - fill_vaddr   in   VA_W                page to install (offset ignored)
// - fill_pcid    in   PCID_W              PCID to install
// - fill_ppn     in   PA_W-PAGE_W         physical page number
// - flush_valid  in   1                   start flush (IDLE only, else ignored)
// - flush_all    in   1                   1=all entries, 0=matching flush_pcid only
// - flush_pcid   in   PCID_W              PCID for selective flush
// - flush_done   out  1                   1-cycle pulse when flush completes
// BEHAVIOUR
// - Reset: all valid bits, all PLRU bits, rsp_valid/rsp_hit/rsp_paddr/rsp_way/flush_done = 0; FSM=IDLE. Tag/ppn storage need not be reset.
// - Address split: set = vaddr[PAGE_W+$clog2(SETS)-1:PAGE_W]; tag = vaddr[VA_W-1:PAGE_W+$clog2(SETS)].
// - Hit: entry valid && tag match && pcid match; at most one way matches (fill guarantees it).
// - req_ready = (state==IDLE) && !fill_valid; fill takes priority over lookup.
// - Lookup accepted in cycle N -> rsp_* valid in N+1 for exactly 1 cycle. Hit: PLRU of set touched with hit way at N+1. Miss: no allocation, PLRU unchanged.
// - Tree PLRU: WAYS-1 bits; node i children 2i+1/2i+2; bit 0 = victim on left. Touch of way w sets every path bit to point away from w.
// - Fill (fill_valid&&fill_ready): way = matching way if tag+pcid already present (overwrite, no duplicate), else lowest-index invalid way, else PLRU victim. Write valid/tag/pcid/ppn and touch way, same cycle.
// - FSM IDLE->FLUSH on flush_valid (flush_valid wins over a same-cycle fill; that fill is not accepted).
// - FLUSH walks set index 0..SETS-1, one set per cycle: clear valid where flush_all or pcid==flush_pcid (inputs captured at entry); clear set PLRU bits when flush_all.
// - FLUSH->IDLE after set SETS-1; flush_done pulses in that last cycle; so flush occupies SETS cycles, req_ready/fill_ready low throughout.
// - Response already in flight when flush starts is still delivered, using pre-flush contents.
// - rst_n asserted mid-flush: immediate return to IDLE, all valids cleared, no flush_done.
// STRUCTURE
// - tlb_pkg: localparams for index/tag widths, entry struct {valid, tag, pcid, ppn}, FSM state enum.
// - Sub-module tlb_plru_tree (combinational): inputs plru bits, touch way; outputs victim way and updated bits. One instance shared by lookup and fill paths, select on fill priority.
// TESTING (SETS=8, WAYS=8)
// - After reset, lookup 0x1000 pcid 1 -> next cycle rsp_valid=1, rsp_hit=0, rsp_paddr=0.
// - Fill vaddr 0x1000 pcid 1 ppn 0x5; lookup 0x1ABC pcid 1 -> rsp_hit=1, rsp_paddr=0x5ABC, rsp_way=0; same vaddr with pcid 2 -> miss.
// - Fill vaddrs k<<15 (k=0..7, set 0) -> ways 0..7 in order; fill 0x40000 -> evicts way 0; lookup 0x0 misses, 0x8000 hits way 1.
// - Refill 0x1000 pcid 1 ppn 0x9 -> overwrites way 0 (no duplicate); lookup returns 0x9000.
// - Entries pcid 1 and 2 present; selective flush pcid 1 -> req_ready low 8 cycles, flush_done pulse cycle 8; pcid 1 misses, pcid 2 hits.
// - flush_valid with fill_valid same cycle -> fill dropped; rst_n low at flush cycle 3 -> no flush_done, all lookups miss.

Source files
------------

// File: rtl/tlb_pkg.sv
// Shared definitions for the set-associative PLRU TLB.
// - Default geometry constants for the reference configuration.
// - FSM state encoding used by the array controller.
package tlb_pkg;

  localparam int unsigned DEF_VA_W   = 64;
  localparam int unsigned DEF_PA_W   = 52;
  localparam int unsigned DEF_PAGE_W = 12;
  localparam int unsigned DEF_PCID_W = 12;
  localparam int unsigned DEF_SETS   = 8;
  localparam int unsigned DEF_WAYS   = 8;

  localparam int unsigned DEF_IDX_W  = $clog2(DEF_SETS);
  localparam int unsigned DEF_WAY_W  = $clog2(DEF_WAYS);
  localparam int unsigned DEF_TAG_W  = DEF_VA_W - DEF_PAGE_W - DEF_IDX_W;
  localparam int unsigned DEF_PPN_W  = DEF_PA_W - DEF_PAGE_W;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_FLUSH = 1'b1
  } tlb_state_e;

endpackage

// File: rtl/tlb_assoc_plru_if.sv
// Bus bundle for tlb_assoc_plru.
// - req_*  : lookup request (valid/ready)
// - rsp_*  : lookup response, one-cycle strobe
// - fill_* : translation install from the page walker
// - flush_*: per-PCID or global invalidation
// master = requester/walker side, slave = TLB side.
interface tlb_assoc_plru_if #(
  parameter int unsigned VA_W   = 64,
  parameter int unsigned PA_W   = 52,
  parameter int unsigned PAGE_W = 12,
  parameter int unsigned PCID_W = 12,
  parameter int unsigned WAYS   = 8
);
  logic                      req_valid;
  logic                      req_ready;
  logic [VA_W-1:0]           req_vaddr;
  logic [PCID_W-1:0]         req_pcid;

  logic                      rsp_valid;
  logic                      rsp_hit;
  logic [PA_W-1:0]           rsp_paddr;
  logic [$clog2(WAYS)-1:0]   rsp_way;

  logic                      fill_valid;
  logic                      fill_ready;
  logic [VA_W-1:0]           fill_vaddr;
  logic [PCID_W-1:0]         fill_pcid;
  logic [PA_W-PAGE_W-1:0]    fill_ppn;

  logic                      flush_valid;
  logic                      flush_all;
  logic [PCID_W-1:0]         flush_pcid;
  logic                      flush_done;

  modport master (
    output req_valid, req_vaddr, req_pcid,
    output fill_valid, fill_vaddr, fill_pcid, fill_ppn,
    output flush_valid, flush_all, flush_pcid,
    input  req_ready, rsp_valid, rsp_hit, rsp_paddr, rsp_way,
    input  fill_ready, flush_done
  );

  modport slave (
    input  req_valid, req_vaddr, req_pcid,
    input  fill_valid, fill_vaddr, fill_pcid, fill_ppn,
    input  flush_valid, flush_all, flush_pcid,
    output req_ready, rsp_valid, rsp_hit, rsp_paddr, rsp_way,
    output fill_ready, flush_done
  );
endinterface

// File: rtl/tlb_plru_tree.sv
// Combinational tree-PLRU helper.
// - plru       : current WAYS-1 tree bits (node i children 2i+1 / 2i+2)
// - touch_way  : way being accessed
// - victim_way : way the current bits point at (bit 0 = go left)
// - plru_next  : bits after touching touch_way (path points away from it)
module tlb_plru_tree #(
  parameter int unsigned WAYS = 8
) (
  input  logic [WAYS-2:0]          plru,
  input  logic [$clog2(WAYS)-1:0]  touch_way,
  output logic [$clog2(WAYS)-1:0]  victim_way,
  output logic [WAYS-2:0]          plru_next
);
  localparam int unsigned LVLS = $clog2(WAYS);

  logic [LVLS-1:0] vnode;
  logic [LVLS-1:0] tnode;

  // Way index bits are MSB-first along the root-to-leaf path, so a left
  // turn contributes 0 and a right turn 1 at each level.
  always_comb begin
    victim_way = '0;
    vnode      = '0;
    for (int unsigned l = 0; l < LVLS; l++) begin
      victim_way[LVLS-1-l] = plru[vnode];
      vnode = LVLS'({vnode, 1'b0}) + LVLS'(1) + LVLS'(plru[vnode]);
    end
  end

  always_comb begin
    plru_next = plru;
    tnode     = '0;
    for (int unsigned l = 0; l < LVLS; l++) begin
      plru_next[tnode] = ~touch_way[LVLS-1-l];
      tnode = LVLS'({tnode, 1'b0}) + LVLS'(1) + LVLS'(touch_way[LVLS-1-l]);
    end
  end
endmodule

// File: rtl/tlb_assoc_plru.sv
// Set-associative, PCID-tagged TLB with tree-PLRU replacement.
// - clk, rst_n : clock, asynchronous active-low reset
// - bus        : slave side of tlb_assoc_plru_if (lookup, response,
//                fill and flush channels)
// Lookup accepted in cycle N responds in N+1; hits touch PLRU. Fills pick
// an existing match, else lowest invalid way, else the PLRU victim. Flush
// walks one set per cycle for SETS cycles.
module tlb_assoc_plru
  import tlb_pkg::*;
#(
  parameter int unsigned VA_W   = 64,
  parameter int unsigned PA_W   = 52,
  parameter int unsigned PAGE_W = 12,
  parameter int unsigned PCID_W = 12,
  parameter int unsigned SETS   = 8,
  parameter int unsigned WAYS   = 8
) (
  input logic            clk,
  input logic            rst_n,
  tlb_assoc_plru_if.slave bus
);
  localparam int unsigned IDX_W = $clog2(SETS);
  localparam int unsigned WAY_W = $clog2(WAYS);
  localparam int unsigned TAG_W = VA_W - PAGE_W - IDX_W;
  localparam int unsigned PPN_W = PA_W - PAGE_W;

  // Entry layout depends on the instance geometry, so it lives here.
  typedef struct packed {
    logic              valid;
    logic [TAG_W-1:0]  tag;
    logic [PCID_W-1:0] pcid;
    logic [PPN_W-1:0]  ppn;
  } entry_t;

  entry_t          mem  [SETS][WAYS];
  logic [WAYS-2:0] plru [SETS];

  tlb_state_e        state_q, state_d;
  logic [IDX_W-1:0]  fidx_q, fidx_d;
  logic              fall_q, fall_d;
  logic [PCID_W-1:0] fpcid_q, fpcid_d;
  logic              flush_done;

  logic [IDX_W-1:0] req_set, fill_set;
  logic [TAG_W-1:0] req_tag, fill_tag;
  logic             req_ready, fill_ready, req_fire, fill_fire;
  logic             fill_off_unused;

  assign req_set  = bus.req_vaddr[PAGE_W +: IDX_W];
  assign req_tag  = bus.req_vaddr[VA_W-1 -: TAG_W];
  assign fill_set = bus.fill_vaddr[PAGE_W +: IDX_W];
  assign fill_tag = bus.fill_vaddr[VA_W-1 -: TAG_W];
  assign fill_off_unused = ^bus.fill_vaddr[PAGE_W-1:0];

  assign req_ready  = (state_q == ST_IDLE) && !bus.fill_valid;
  assign fill_ready = (state_q == ST_IDLE) && !bus.flush_valid;
  assign req_fire   = bus.req_valid && req_ready;
  assign fill_fire  = bus.fill_valid && fill_ready;

  // Lookup match
  logic             req_hit;
  logic [WAY_W-1:0] req_way;
  always_comb begin
    req_hit = 1'b0;
    req_way = '0;
    for (int unsigned w = 0; w < WAYS; w++) begin
      if (mem[req_set][w].valid && mem[req_set][w].tag == req_tag &&
          mem[req_set][w].pcid == bus.req_pcid) begin
        req_hit = 1'b1;
        req_way = WAY_W'(w);
      end
    end
  end

  // Fill way selection: existing match, else lowest invalid
  logic             fill_match, fill_inv;
  logic [WAY_W-1:0] fill_match_way, fill_inv_way, fill_way, victim_way;
  always_comb begin
    fill_match     = 1'b0;
    fill_match_way = '0;
    fill_inv       = 1'b0;
    fill_inv_way   = '0;
    for (int unsigned w = 0; w < WAYS; w++) begin
      if (mem[fill_set][w].valid && mem[fill_set][w].tag == fill_tag &&
          mem[fill_set][w].pcid == bus.fill_pcid) begin
        fill_match     = 1'b1;
        fill_match_way = WAY_W'(w);
      end
      if (!mem[fill_set][w].valid && !fill_inv) begin
        fill_inv     = 1'b1;
        fill_inv_way = WAY_W'(w);
      end
    end
  end

  assign fill_way = fill_match ? fill_match_way :
                    fill_inv   ? fill_inv_way   : victim_way;

  // One PLRU tree for both paths; a pending fill owns it, which never
  // conflicts with a lookup because req_ready drops while fill_valid is high.
  logic [WAYS-2:0]  plru_sel, plru_upd;
  logic [WAY_W-1:0] touch_way;
  assign plru_sel  = bus.fill_valid ? plru[fill_set] : plru[req_set];
  assign touch_way = bus.fill_valid ? fill_way : req_way;

  tlb_plru_tree #(.WAYS(WAYS)) u_plru (
    .plru       (plru_sel),
    .touch_way  (touch_way),
    .victim_way (victim_way),
    .plru_next  (plru_upd)
  );

  // FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      fidx_q  <= '0;
      fall_q  <= 1'b0;
      fpcid_q <= '0;
    end else begin
      state_q <= state_d;
      fidx_q  <= fidx_d;
      fall_q  <= fall_d;
      fpcid_q <= fpcid_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    fidx_d     = fidx_q;
    fall_d     = fall_q;
    fpcid_d    = fpcid_q;
    flush_done = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.flush_valid) begin
          state_d = ST_FLUSH;
          fidx_d  = '0;
          fall_d  = bus.flush_all;
          fpcid_d = bus.flush_pcid;
        end
      end
      ST_FLUSH: begin
        fidx_d = fidx_q + IDX_W'(1);
        if (fidx_q == IDX_W'(SETS - 1)) begin
          state_d    = ST_IDLE;
          flush_done = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Array and PLRU state; only valid bits and PLRU are reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned s = 0; s < SETS; s++) begin
        plru[s] <= '0;
        for (int unsigned w = 0; w < WAYS; w++) mem[s][w].valid <= 1'b0;
      end
    end else if (state_q == ST_FLUSH) begin
      for (int unsigned w = 0; w < WAYS; w++) begin
        if (fall_q || mem[fidx_q][w].pcid == fpcid_q) mem[fidx_q][w].valid <= 1'b0;
      end
      if (fall_q) plru[fidx_q] <= '0;
    end else if (fill_fire) begin
      mem[fill_set][fill_way] <= '{valid: 1'b1, tag: fill_tag,
                                   pcid: bus.fill_pcid, ppn: bus.fill_ppn};
      plru[fill_set] <= plru_upd;
    end else if (req_fire && req_hit) begin
      plru[req_set] <= plru_upd;
    end
  end

  // Response register, computed from contents at accept time.
  logic             rsp_valid_q, rsp_hit_q;
  logic [PA_W-1:0]  rsp_paddr_q;
  logic [WAY_W-1:0] rsp_way_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_q <= 1'b0;
      rsp_hit_q   <= 1'b0;
      rsp_paddr_q <= '0;
      rsp_way_q   <= '0;
    end else begin
      rsp_valid_q <= req_fire;
      if (req_fire) begin
        rsp_hit_q   <= req_hit;
        rsp_paddr_q <= req_hit ? {mem[req_set][req_way].ppn, bus.req_vaddr[PAGE_W-1:0]} : '0;
        rsp_way_q   <= req_hit ? req_way : '0;
      end
    end
  end

  assign bus.req_ready  = req_ready;
  assign bus.fill_ready = fill_ready;
  assign bus.flush_done = flush_done;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_hit    = rsp_hit_q;
  assign bus.rsp_paddr  = rsp_paddr_q;
  assign bus.rsp_way    = rsp_way_q;
endmodule
